apb_req_master: RTL and testbench

//  APB4 requester (master): turns a valid/ready request/response port into APB4 transfers.
//  It is the initiator counterpart of the apb_regs slave register file.
//  It sits between a config/DMA-side requester and an APB slave (e.g. apb_regs) or demux.
//  One transfer is outstanding at a time. Responses are held in a one-entry response register.
//  An optional access-phase timeout turns a hung slave into an error response.

---
 rtl/apb_req_master_pkg.sv | 19 +
 rtl/apb_req_master.sv | 139 +++++++++++++
 tb/tb_apb_req_master.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_pkg.sv
// Shared types and helpers for the APB4 requester.
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  typedef logic [2:0] prot_t;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/apb_req_master.sv
// APB4 requester: one outstanding valid/ready request turned into an APB4 transfer,
// with a one-entry response register and an optional access-phase timeout.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  localparam int unsigned StrbWidth    = ceil_div(DataWidth, 8)
) (
  input  logic                 pclk_i,
  input  logic                 preset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [StrbWidth-1:0] req_strb_i,
  input  prot_t                req_prot_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [AddrWidth-1:0] paddr_o,
  output prot_t                pprot_o,
  output logic                 pwrite_o,
  output logic [DataWidth-1:0] pwdata_o,
  output logic [StrbWidth-1:0] pstrb_o,
  output logic                 psel_o,
  output logic                 penable_o,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  input  logic [DataWidth-1:0] prdata_i
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CntMax = '1;

  state_e                 state_q;
  logic                   psel_q, penable_q;
  logic [AddrWidth-1:0]   addr_q;
  prot_t                  prot_q;
  logic                   write_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   strb_q;
  logic [CntWidth-1:0]    cnt_q;
  logic                   rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DataWidth-1:0]   rsp_rdata_q;
  logic                   timeout_hit;

  // A new request is only taken when the response slot is free (or being freed this cycle).
  assign req_ready_o = (state_q == StIdle) && !preset_i && (!rsp_valid_q || rsp_ready_i);

  // pready on the threshold cycle takes priority over the abort.
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast) && !pready_i;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q       <= StIdle;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      addr_q        <= '0;
      prot_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      strb_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q   <= 1'b0;
        rsp_err_q     <= 1'b0;
        rsp_timeout_q <= 1'b0;
        rsp_rdata_q   <= '0;
      end
      case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_o) begin
            state_q <= StSetup;
            psel_q  <= 1'b1;
            addr_q  <= req_addr_i;
            prot_q  <= req_prot_i;
            write_q <= req_write_i;
            wdata_q <= req_write_i ? req_wdata_i : '0;
            strb_q  <= req_write_i ? req_strb_i : '0;
            cnt_q   <= '0;
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (pready_i || timeout_hit) begin
            state_q       <= StIdle;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            addr_q        <= '0;
            prot_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= !pready_i;
            if (pready_i) begin
              rsp_err_q   <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
              rsp_rdata_q <= (!write_q && !pslverr_i) ? prdata_i : '0;
            end else begin
              rsp_err_q   <= RESP_SLVERR;
              rsp_rdata_q <= '0;
            end
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign paddr_o       = addr_q;
  assign pprot_o       = prot_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: scripted-pready stub slave with a small memory, directed
// vector table, multi-cycle corner sequences and a random back-to-back phase.
module tb_apb_req_master;
  import apb_req_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  prot_t       req_prot = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  prot_t       pprot;
  logic        pwrite, psel, penable, pready, pslverr;
  logic [3:0]  pstrb;

  always #5 clk = ~clk;

  apb_req_master #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(8)
  ) dut (
    .pclk_i       (clk),
    .preset_i     (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_write_i  (req_write),
    .req_wdata_i  (req_wdata),
    .req_strb_i   (req_strb),
    .req_prot_i   (req_prot),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .paddr_o      (paddr),
    .pprot_o      (pprot),
    .pwrite_o     (pwrite),
    .pwdata_o     (pwdata),
    .pstrb_o      (pstrb),
    .psel_o       (psel),
    .penable_o    (penable),
    .pready_i     (pready),
    .pslverr_i    (pslverr),
    .prdata_i     (prdata)
  );

  // Stub slave: mode 0 = memory, 1 = fixed prdata, 2 = never ready.
  int unsigned slv_mode = 0, slv_waits = 0, acc_cnt = 0;
  logic        slv_err = 1'b0, pready_force = 1'b0;
  logic [31:0] slv_prdata = '0;
  logic [31:0] mem [16];
  logic [31:0] model [16];

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++) if (pstrb[b]) mem[paddr[5:2]][8*b+:8] <= pwdata[8*b+:8];
  end

  always_comb begin
    pready  = pready_force || (psel && penable && slv_mode != 2 && acc_cnt == slv_waits);
    pslverr = pready && slv_err && psel && penable;
    prdata  = (slv_mode == 1) ? slv_prdata : mem[paddr[5:2]];
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol monitor.
  logic        prev_psel = 1'b0, prev_pen = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [7:0]  prev_ctl;
  always @(negedge clk) begin
    if (psel) begin
      check("no_x_while_psel", {31'b0, $isunknown({paddr, pwdata, pstrb, pwrite, pprot, penable})}, 0);
      check("psel_with_rsp_full", {31'b0, rsp_valid}, 0);
      if (prev_psel && !prev_pen) check("setup_to_access", {31'b0, penable}, 1);
      if (prev_psel && prev_pen) begin
        check("stable_addr", paddr, prev_addr);
        check("stable_wdata", pwdata, prev_wdata);
        check("stable_ctl", {24'b0, pstrb, pwrite, pprot}, {24'b0, prev_ctl});
      end
      if (!pwrite) check("read_strb_wdata_zero", {28'b0, pstrb} | pwdata, 0);
    end else if (!rst) begin
      check("idle_fields_zero", paddr | pwdata | {24'b0, pstrb, pwrite, pprot, penable}, 0);
    end
    prev_psel  <= psel;
    prev_pen   <= penable;
    prev_addr  <= paddr;
    prev_wdata <= pwdata;
    prev_ctl   <= {pstrb, pwrite, pprot};
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                       output logic tmo, output int lat, output int pen, output logic bad);
    int n;
    @(negedge clk);
    req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    req_prot = 3'b010; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; pen = 0; bad = 1'b0;
    while (!rsp_valid && lat < 60) begin
      if (penable) pen++;
      if (psel && (paddr !== addr || pprot !== 3'b010 || pwrite !== wr)) bad = 1'b1;
      @(negedge clk); lat++;
    end
    check("rsp_valid_wait", {31'b0, rsp_valid}, 1);
    rdata = rsp_rdata; err = rsp_err; tmo = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int unsigned mode, waits;
    logic        err;
    logic [31:0] prdata, exp_rdata;
    logic        exp_err, exp_tmo;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] rd;
  logic        er, tm, bad;
  int          lat, pen, n;

  initial begin
    vecs[0] = '{1'b1, 32'h3_0000, 32'h0000_1234, 4'hF, 0, 0, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h3_0000, 32'h0,         4'h0, 0, 0, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, 32'h3_0010, 32'h0,         4'h0, 1, 3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 6};
    vecs[3] = '{1'b0, 32'h3_0014, 32'h0,         4'h0, 1, 0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b1, 32'h3_0004, 32'hAABB_CCDD, 4'h5, 0, 1, 1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h3_0004, 32'h0,         4'h0, 0, 0, 1'b0, 32'h0, 32'h00BB_00DD, 1'b0, 1'b0, 3};
    vecs[6] = '{1'b1, 32'h3_0008, 32'h5555_5555, 4'hF, 0, 2, 1'b1, 32'h0, 32'h0,         1'b1, 1'b0, 5};
    vecs[7] = '{1'b0, 32'h3_0000, 32'h0,         4'h0, 2, 0, 1'b0, 32'h1, 32'h0,         1'b1, 1'b1, 10};
    vecs[8] = '{1'b0, 32'h3_0000, 32'h0,         4'h0, 0, 7, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 10};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'b0, req_ready, rsp_valid, psel, penable, rsp_err}, 0);
    check("reset_data", rsp_rdata | paddr | pwdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 1);

    foreach (vecs[i]) begin
      slv_mode = vecs[i].mode; slv_waits = vecs[i].waits;
      slv_err = vecs[i].err; slv_prdata = vecs[i].prdata;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, tm, lat, pen, bad);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_timeout", i), {31'b0, tm}, {31'b0, vecs[i].exp_tmo});
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_penable_cycles", i), pen, vecs[i].exp_lat - 2);
      check($sformatf("v%0d_apb_fields", i), {31'b0, bad}, 0);
      if (vecs[i].exp_tmo) begin
        // Late pready after an abort must not produce a second response.
        pready_force = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check("late_pready_no_rsp", {30'b0, rsp_valid, psel}, 0);
        end
        pready_force = 1'b0;
      end
    end
    slv_mode = 0; slv_waits = 0; slv_err = 1'b0;

    // Response backpressure: requester stalls until the response is consumed.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h3_0018; req_wdata = 32'hCAFE_F00D; req_strb = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    req_write = 1'b0; req_strb = 4'h0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_first_rsp", {31'b0, rsp_valid}, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_stall", {29'b0, req_ready, psel, rsp_valid}, 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_on_consume", {31'b0, req_ready}, 1);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("bp_after_consume", {30'b0, rsp_valid, psel}, 32'h1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_read_rdata", rsp_rdata, 32'hCAFE_F00D);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during ACCESS.
    slv_mode = 2;
    @(negedge clk);
    req_addr = 32'h3_0000; req_valid = 1'b1;
    while (!req_ready) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_in_access_pre", {30'b0, psel, penable}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_access_post", {28'b0, psel, penable, rsp_valid, req_ready}, 0);
    rst = 1'b0;
    slv_mode = 0;
    issue(1'b1, 32'h3_001C, 32'h0000_0055, 4'hF, rd, er, tm, lat, pen, bad);
    check("post_rst_write", {30'b0, er, tm}, 0);
    check("post_rst_latency", lat, 3);

    // Pending response is dropped by reset.
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h3_001C; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_drops_rsp", {31'b0, rsp_valid}, 0);

    // Known memory contents, then random back-to-back traffic against the model.
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h1000_0000 + i;
      issue(1'b1, 32'h3_0000 | (i << 2), model[i], 4'hF, rd, er, tm, lat, pen, bad);
    end
    for (int k = 0; k < 100; k++) begin
      logic        wr;
      int unsigned idx;
      logic [31:0] wd;
      logic [3:0]  st;
      wr = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      slv_waits = $urandom_range(0, 3);
      issue(wr, 32'h3_0000 | (idx << 2), wd, st, rd, er, tm, lat, pen, bad);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (st[b]) model[idx][8*b+:8] = wd[8*b+:8];
        check("rand_wr_rdata", rd, 0);
      end else begin
        check("rand_rd_rdata", rd, model[idx]);
      end
      check("rand_err", {30'b0, er, tm}, 0);
      check("rand_latency", lat, 3 + slv_waits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
